// File: rtl/dmem_responder_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// responder (slave).
//   mem_addr_i        byte address
//   mem_write_data_i  store data
//   mem_wen_i         write request
//   mem_wstrb_i       byte-lane write strobes (bit n -> bits 8n+7:8n)
//   mem_ren_i         read request
//   mem_read_data_o   registered read data
//   mem_ready_o       one-cycle completion pulse
//   mem_err_o         error flag, meaningful only with mem_ready_o
interface dmem_responder_if;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_write_data_i;
  logic        mem_wen_i;
  logic [3:0]  mem_wstrb_i;
  logic        mem_ren_i;
  logic [31:0] mem_read_data_o;
  logic        mem_ready_o;
  logic        mem_err_o;

  modport master (
    output mem_addr_i,
    output mem_write_data_i,
    output mem_wen_i,
    output mem_wstrb_i,
    output mem_ren_i,
    input  mem_read_data_o,
    input  mem_ready_o,
    input  mem_err_o
  );

  modport slave (
    input  mem_addr_i,
    input  mem_write_data_i,
    input  mem_wen_i,
    input  mem_wstrb_i,
    input  mem_ren_i,
    output mem_read_data_o,
    output mem_ready_o,
    output mem_err_o
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory with a fixed number of wait states per access.
// A request is accepted in IDLE, spends WAIT_CYCLES cycles in WAIT and
// completes with a one-cycle RESP carrying mem_ready_o (and mem_err_o).
//   clk  sole clock, rising edge
//   rst  synchronous active-high reset
//   bus  slave side of dmem_responder_if
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AddrW    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] HiMask   = ~((32'd1 << (AddrW + 2)) - 32'd1);
  localparam logic [2:0]  WaitInit = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic        wen_q, wen_d;
  logic        ren_q, ren_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;

  logic [31:0] mem_q [DEPTH_WORDS];

  // With zero wait states the access completes on the accepting edge, so the
  // live inputs are used there; otherwise the captured copy is used.
  logic [31:0]      acc_addr, acc_wdata;
  logic [3:0]       acc_wstrb;
  logic             acc_wen, acc_ren, acc_err;
  logic [AddrW-1:0] acc_idx;
  logic             accept, go_resp, mem_we;

  always_comb begin
    if (state_q == StIdle) begin
      acc_addr  = bus.mem_addr_i;
      acc_wdata = bus.mem_write_data_i;
      acc_wstrb = bus.mem_wstrb_i;
      acc_wen   = bus.mem_wen_i;
      acc_ren   = bus.mem_ren_i;
    end else begin
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wstrb = wstrb_q;
      acc_wen   = wen_q;
      acc_ren   = ren_q;
    end
    acc_idx = acc_addr[AddrW+1:2];
    acc_err = (|(acc_addr & HiMask)) || (acc_wen && acc_ren);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    wen_d   = wen_q;
    ren_d   = ren_q;
    rdata_d = rdata_q;
    ready_d = 1'b0;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    accept  = (state_q == StIdle) && (bus.mem_wen_i || bus.mem_ren_i);
    go_resp = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = bus.mem_addr_i;
          wdata_d = bus.mem_write_data_i;
          wstrb_d = bus.mem_wstrb_i;
          wen_d   = bus.mem_wen_i;
          ren_d   = bus.mem_ren_i;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            go_resp = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 3'd0) begin
          state_d = StResp;
          go_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Everything observable happens on the edge entering RESP.
    if (go_resp) begin
      ready_d = 1'b1;
      err_d   = acc_err;
      if (acc_err) begin
        rdata_d = '0;
      end else if (acc_ren) begin
        rdata_d = mem_q[acc_idx];
      end else if (acc_wen) begin
        mem_we = ~rst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      wen_q   <= 1'b0;
      ren_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      wen_q   <= wen_d;
      ren_q   <= ren_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wstrb[b]) begin
          mem_q[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.mem_read_data_o = rdata_q;
  assign bus.mem_ready_o     = ready_q;
  assign bus.mem_err_o       = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (0, 1 and 7 wait states, 1024
// words) exercised with directed cases and random traffic against a
// word-array reference model.
module tb_dmem_responder;

  localparam int NDut = 3;
  localparam int Depth = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] tb_addr  [NDut];
  logic [31:0] tb_wdata [NDut];
  logic        tb_wen   [NDut];
  logic [3:0]  tb_wstrb [NDut];
  logic        tb_ren   [NDut];
  logic [31:0] tb_rdata [NDut];
  logic        tb_ready [NDut];
  logic        tb_err   [NDut];

  int wait_of [NDut] = '{0, 1, 7};

  for (genvar g = 0; g < NDut; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 0 : ((g == 1) ? 1 : 7);
    dmem_responder_if bus ();
    assign bus.mem_addr_i       = tb_addr[g];
    assign bus.mem_write_data_i = tb_wdata[g];
    assign bus.mem_wen_i        = tb_wen[g];
    assign bus.mem_wstrb_i      = tb_wstrb[g];
    assign bus.mem_ren_i        = tb_ren[g];
    assign tb_rdata[g]          = bus.mem_read_data_o;
    assign tb_ready[g]          = bus.mem_ready_o;
    assign tb_err[g]            = bus.mem_err_o;
    dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(W)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Reference model
  logic [31:0] ref_mem  [NDut][Depth];
  logic [31:0] ref_rd   [NDut];
  int          written  [NDut][$];
  bit          was_wr   [NDut][Depth];

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input int k);
    tb_wen[k] = 1'b0;
    tb_ren[k] = 1'b0;
  endtask

  // Latency is counted in cycles, inclusively, from the cycle the request is
  // presented to the cycle mem_ready_o is high; 0 means it never came.
  task automatic access(input int k, input logic w, input logic r, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] s,
                        output logic [31:0] rd, output logic er, output int lat);
    bit seen;
    @(posedge clk); #1;
    tb_addr[k] = a; tb_wdata[k] = wd; tb_wstrb[k] = s; tb_wen[k] = w; tb_ren[k] = r;
    rd = 'x; er = 1'bx; lat = 0; seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge clk); #1;
      if (tb_ready[k]) begin
        seen = 1; lat = i + 2; rd = tb_rdata[k]; er = tb_err[k];
      end
    end
    idle_inputs(k);
  endtask

  task automatic run_op(input int k, input string tag, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] s);
    logic [31:0] rd, exp_rd, cur;
    logic        er, exp_er;
    int          lat, idx;
    idx    = int'(a[11:2]);
    exp_er = (a[31:12] != 0) || (w && r);
    if (exp_er) exp_rd = 32'h0;
    else if (r) exp_rd = ref_mem[k][idx];
    else exp_rd = ref_rd[k];
    access(k, w, r, a, wd, s, rd, er, lat);
    check_eq({tag, ".lat"}, lat, wait_of[k] + 2);
    check_eq({tag, ".err"}, {31'b0, er}, {31'b0, exp_er});
    check_eq({tag, ".rdata"}, rd, exp_rd);
    ref_rd[k] = exp_rd;
    if (!exp_er && w) begin
      cur = ref_mem[k][idx];
      for (int b = 0; b < 4; b++) if (s[b]) cur[8*b +: 8] = wd[8*b +: 8];
      ref_mem[k][idx] = cur;
      if (s == 4'hF && !was_wr[k][idx]) begin
        was_wr[k][idx] = 1;
        written[k].push_back(idx);
      end
    end
  endtask

  task automatic reset_outputs_check(input string tag);
    for (int k = 0; k < NDut; k++) begin
      check_eq($sformatf("%s.ready%0d", tag, k), {31'b0, tb_ready[k]}, 32'h0);
      check_eq($sformatf("%s.err%0d", tag, k), {31'b0, tb_err[k]}, 32'h0);
      check_eq($sformatf("%s.rdata%0d", tag, k), tb_rdata[k], 32'h0);
      ref_rd[k] = 32'h0;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, pulses, last_edge, edge_n, sel, idx;
    bit          any_ready;
    logic [31:0] alt_addr [2];
    logic [31:0] a;

    for (int k = 0; k < NDut; k++) begin
      tb_addr[k] = 0; tb_wdata[k] = 0; tb_wstrb[k] = 0; idle_inputs(k);
    end
    repeat (3) @(posedge clk);
    #1;
    reset_outputs_check("reset");
    rst = 1'b0;

    // Full write then read, one wait state
    run_op(1, "wr40", 1, 0, 32'h40, 32'hDEADBEEF, 4'hF);
    run_op(1, "rd40", 0, 1, 32'h40, 32'h0, 4'h0);
    check_eq("rd40.value", ref_rd[1], 32'hDEADBEEF);

    // Byte strobes
    run_op(1, "wr80", 1, 0, 32'h80, 32'h11223344, 4'hF);
    run_op(1, "wr80s", 1, 0, 32'h80, 32'hAABBCCDD, 4'b0101);
    run_op(1, "rd80", 0, 1, 32'h83, 32'h0, 4'h0);
    check_eq("rd80.value", ref_rd[1], 32'h11BB33DD);
    run_op(1, "wr80z", 1, 0, 32'h80, 32'hFFFFFFFF, 4'b0000);
    run_op(1, "rd80z", 0, 1, 32'h80, 32'h0, 4'h0);

    // Error cases
    run_op(1, "rdoor", 0, 1, 32'h0000_1000, 32'h0, 4'h0);
    run_op(1, "wroor", 1, 0, 32'h0000_1040, 32'h55555555, 4'hF);
    run_op(1, "rd40b", 0, 1, 32'h40, 32'h0, 4'h0);
    run_op(1, "both", 1, 1, 32'h40, 32'h77777777, 4'hF);
    run_op(1, "rd40c", 0, 1, 32'h40, 32'h0, 4'h0);
    check_eq("rd40c.value", ref_rd[1], 32'hDEADBEEF);

    // Reset in the middle of a write on the 7-wait-state instance
    run_op(2, "pre40", 1, 0, 32'h40, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    tb_addr[2] = 32'h40; tb_wdata[2] = 32'h12345678; tb_wstrb[2] = 4'hF; tb_wen[2] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs(2);
    @(posedge clk); #1;
    reset_outputs_check("midrst");
    rst = 1'b0;
    any_ready = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (tb_ready[2]) any_ready = 1;
    end
    check_eq("midrst.noready", {31'b0, any_ready}, 32'h0);
    run_op(2, "postrst", 0, 1, 32'h40, 32'h0, 4'h0);
    check_eq("postrst.value", ref_rd[2], 32'hCAFEF00D);

    // Back-to-back reads held on the zero-wait instance
    run_op(0, "bbw0", 1, 0, 32'h100, 32'hA5A5_0001, 4'hF);
    run_op(0, "bbw1", 1, 0, 32'h204, 32'h5A5A_0002, 4'hF);
    alt_addr[0] = 32'h100; alt_addr[1] = 32'h204;
    @(posedge clk); #1;
    tb_addr[0] = alt_addr[0]; tb_ren[0] = 1'b1;
    pulses = 0; last_edge = 0; edge_n = 0;
    while (pulses < 6 && edge_n < 40) begin
      @(posedge clk); #1;
      edge_n++;
      if (tb_ready[0]) begin
        check_eq($sformatf("b2b.data%0d", pulses), tb_rdata[0], ref_mem[0][alt_addr[pulses % 2][11:2]]);
        check_eq($sformatf("b2b.err%0d", pulses), {31'b0, tb_err[0]}, 32'h0);
        if (pulses > 0) check_eq($sformatf("b2b.gap%0d", pulses), edge_n - last_edge, 2);
        last_edge = edge_n;
        pulses++;
        tb_addr[0] = alt_addr[pulses % 2];
      end
    end
    check_eq("b2b.pulses", pulses, 6);
    idle_inputs(0);
    ref_rd[0] = ref_mem[0][alt_addr[1][11:2]];

    // Random traffic
    for (int k = 0; k < NDut; k++) begin
      for (int n = 0; n < 40; n++) begin
        sel = $urandom_range(0, 9);
        if (sel < 4 || written[k].size() == 0) begin
          idx = $urandom_range(0, Depth - 1);
          run_op(k, "rnd.wr", 1, 0, {20'b0, idx[9:0], 2'($urandom)}, $urandom,
                 was_wr[k][idx] ? 4'($urandom) : 4'hF);
        end else begin
          idx = written[k][$urandom_range(0, written[k].size() - 1)];
          a = {20'b0, idx[9:0], 2'($urandom)};
          if (sel < 8) begin
            run_op(k, "rnd.rd", 0, 1, a, 32'h0, 4'h0);
          end else begin
            if (sel == 8) a[31:12] = 20'($urandom_range(1, 20'hFFFFF));
            run_op(k, "rnd.err", 1, sel == 9, a, $urandom, 4'hF);
            run_op(k, "rnd.chk", 0, 1, {20'b0, idx[9:0], 2'b00}, 32'h0, 4'h0);
          end
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
